// File: rtl/bw_seq_mult_7x5.sv
// Iterative signed 7x5 Baugh-Wooley multiplier.
// One row of seven AND-FA cells is reused for each bit of b, with sum and carry
// kept in registers between rows; a final carry-propagate cycle forms the
// 12-bit two's-complement product.
module bw_seq_mult_7x5 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  a,
  input  logic [4:0]  b,
  output logic        busy,
  output logic        done,
  output logic [11:0] product
);

  typedef enum logic [1:0] {StIdle, StRow, StAdd} state_e;

  state_e      state_q, state_d;
  logic [6:0]  a_q, a_d;
  logic [4:0]  b_q, b_d;
  logic [6:0]  s_q, s_d;
  logic [6:0]  c_q, c_d;
  logic [2:0]  j_q, j_d;
  logic [4:0]  lo_q, lo_d;
  logic [11:0] product_q, product_d;
  logic        done_q, done_d;

  logic        b_bit;
  logic        last_row;
  logic [6:0]  pp;
  logic [6:0]  s_shift;
  logic [6:0]  row_sum;
  logic [6:0]  row_carry;
  logic [6:0]  hi;
  logic [11:0] prod_fix;

  // One cell row: Baugh-Wooley partial products added to shifted S and C.
  always_comb begin
    b_bit    = b_q[j_q];
    last_row = (j_q == 3'd4);
    for (int i = 0; i < 7; i++) begin
      pp[i] = a_q[i] & b_bit;
      // Sign-weighted terms are inverted; a_6&b_4 keeps positive weight.
      if (last_row) begin
        if (i < 6) pp[i] = ~pp[i];
      end else if (i == 6) begin
        pp[i] = ~pp[i];
      end
    end
    // Cell i sees S bit i+1 from the previous row; the top cell sees zero.
    s_shift   = {1'b0, s_q[6:1]};
    row_sum   = pp ^ s_shift ^ c_q;
    row_carry = (pp & s_shift) | (pp & c_q) | (s_shift & c_q);
    // Carry-propagate of the residual S/C, then the 0x850 correction mod 2^12.
    hi        = s_shift + c_q;
    prod_fix  = {hi, lo_q} + 12'h850;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    c_d       = c_q;
    j_d       = j_q;
    lo_d      = lo_q;
    product_d = product_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          s_d     = '0;
          c_d     = '0;
          j_d     = 3'd0;
          lo_d    = '0;
          state_d = StRow;
        end
      end
      StRow: begin
        lo_d[j_q] = row_sum[0];
        s_d       = row_sum;
        c_d       = row_carry;
        if (last_row) begin
          j_d     = 3'd0;
          state_d = StAdd;
        end else begin
          j_d = j_q + 3'd1;
        end
      end
      StAdd: begin
        product_d = prod_fix;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      c_q       <= '0;
      j_q       <= '0;
      lo_q      <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      s_q       <= s_d;
      c_q       <= c_d;
      j_q       <= j_d;
      lo_q      <= lo_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_bw_seq_mult_7x5.sv
// Scoreboard bench for bw_seq_mult_7x5: the driver pushes expected products
// with their due cycle, the monitor pops and compares on every done pulse.
module tb_bw_seq_mult_7x5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  a;
  logic [4:0]  b;
  logic        busy;
  logic        done;
  logic [11:0] product;

  typedef struct {
    logic [11:0] prod;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_done = 0;

  bw_seq_mult_7x5 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      n_done++;
      n_vec++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got done=1 product=%h at cycle %0d, required no done",
                 product, cyc);
      end else begin
        e = q.pop_front();
        if (product !== e.prod || cyc != e.due || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL result: got product=%h cycle=%0d busy=%b, required product=%h cycle=%0d busy=0",
                   product, cyc, busy, e.prod, e.due);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h), required %0d (0x%h)", nm, got, got, exp, exp);
    end
  endtask

  // Called at a negedge; waits for idle, presents the operands with start high,
  // and records when done is due (accept edge + 6, sampled on the next negedge).
  task automatic issue(input logic [6:0] av, input logic [4:0] bv, input logic [11:0] ev);
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_vec++;
      n_fail++;
      $display("FAIL issue_timeout: got busy=1 after 20 cycles, required busy=0");
    end else begin
      a     = av;
      b     = bv;
      start = 1'b1;
      q.push_back('{ev, cyc + 7});
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d outstanding results, required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    int d0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    repeat (4) begin
      @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
      chk("idle_product", int'(product), 0);
    end

    // Basic and sign corners.
    issue(7'd3, 5'd5, 12'h00F);       start = 1'b0; drain();
    issue(7'h40, 5'h10, 12'h400);     start = 1'b0; drain();
    issue(7'd63, 5'd15, 12'h3B1);     start = 1'b0; drain();
    issue(7'h40, 5'd15, 12'hC40);     start = 1'b0; drain();
    issue(7'd63, 5'h10, 12'hC10);     start = 1'b0; drain();
    issue(7'd0, 5'h1F, 12'h000);      start = 1'b0; drain();

    // Busy lockout: a start pulse two edges after accept is ignored.
    d0 = n_done;
    issue(7'd5, 5'd3, 12'h00F);
    start = 1'b0;
    @(negedge clk);
    a     = 7'h7F;
    b     = 5'h1F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (10) @(negedge clk);
    chk("lockout_done_count", n_done - d0, 1);
    chk("lockout_busy", int'(busy), 0);
    chk("lockout_product", int'(product), 12'h00F);

    // Back-to-back with start held high.
    issue(7'h7F, 5'h1F, 12'h001);
    issue(7'd7, 5'h1D, 12'hFEB);
    start = 1'b0;
    drain();

    // Reset in the middle of an operation.
    issue(7'd10, 5'd10, 12'h064);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    void'(q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    chk("abort_product", int'(product), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    repeat (8) @(negedge clk);
    chk("abort_idle_busy", int'(busy), 0);
    issue(7'd10, 5'd10, 12'h064);
    start = 1'b0;
    drain();

    // Exhaustive back-to-back sweep against a signed product model.
    d0 = n_done;
    for (int ai = 0; ai < 128; ai++) begin
      for (int bi = 0; bi < 32; bi++) begin
        logic signed [6:0] sa;
        logic signed [4:0] sb;
        int p;
        sa = ai[6:0];
        sb = bi[4:0];
        p  = sa * sb;
        issue(ai[6:0], bi[4:0], p[11:0]);
      end
    end
    start = 1'b0;
    drain();
    chk("sweep_done_count", n_done - d0, 4096);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
